// File: rtl/tsync_rx_multi.sv
// tsync_rx_multi: multi-channel toggle synchroniser receiver with per-channel
// saturating pending-event counters behind a valid/ready handshake.
module tsync_rx_multi #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       toggle_in,
  output logic [NUM_CH-1:0]       evt_valid,
  input  logic [NUM_CH-1:0]       evt_ready,
  output logic [NUM_CH*CNT_W-1:0] pending_cnt,
  output logic [NUM_CH-1:0]       overflow,
  input  logic [NUM_CH-1:0]       clear_ovf
);

  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("tsync_rx_multi: SYNC_STAGES must be >= 2");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] sync_d [SYNC_STAGES];
  logic [NUM_CH-1:0] hist_q, hist_d;
  logic [NUM_CH-1:0] tgl_edge;
  logic [NUM_CH-1:0] accept;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] ovf_q, ovf_d;

  always_comb begin
    sync_d[0] = toggle_in;
    for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
    hist_d   = sync_q[SYNC_STAGES-1];
    tgl_edge = sync_q[SYNC_STAGES-1] ^ hist_q;
  end

  always_comb begin
    pending_cnt = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      evt_valid[i]                    = (cnt_q[i] != '0);
      pending_cnt[i*CNT_W +: CNT_W]   = cnt_q[i];
    end
    overflow = ovf_q;
    accept   = evt_valid & evt_ready;
  end

  // Simultaneous inc and dec cancel, so a full counter accepting while a new
  // edge arrives neither moves nor flags overflow; a lost increment beats clear.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      ovf_d[i] = ovf_q[i] & ~clear_ovf[i];
      if (tgl_edge[i] && !accept[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          ovf_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else if (!tgl_edge[i] && accept[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
      hist_q <= '0;
      ovf_q  <= '0;
    end else begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      hist_q <= hist_d;
      ovf_q  <= ovf_d;
    end
  end

endmodule

// File: tb/tb_tsync_rx_multi.sv
// Scoreboard bench for tsync_rx_multi: stimulus pushes cycle-tagged expected
// observations; a negedge monitor pops and compares them and counts handshakes.
module tb_tsync_rx_multi;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_CH-1:0]       tog;
  logic [NUM_CH-1:0]       evt_valid;
  logic [NUM_CH-1:0]       evt_ready;
  logic [NUM_CH*CNT_W-1:0] pending_cnt;
  logic [NUM_CH-1:0]       overflow;
  logic [NUM_CH-1:0]       clear_ovf;

  logic [0:0]       tog3;
  logic [0:0]       valid3;
  logic [0:0]       ready3 = 1'b0;
  logic [CNT_W-1:0] pend3;
  logic [0:0]       ovf3;
  logic [0:0]       clr3 = 1'b0;

  always #5 clk = ~clk;

  tsync_rx_multi #(.NUM_CH(NUM_CH), .SYNC_STAGES(2), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .toggle_in(tog), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .pending_cnt(pending_cnt), .overflow(overflow),
    .clear_ovf(clear_ovf)
  );

  always_comb tog3 = tog[0:0];

  tsync_rx_multi #(.NUM_CH(1), .SYNC_STAGES(3), .CNT_W(CNT_W)) u_dut3 (
    .clk(clk), .rst(rst), .toggle_in(tog3), .evt_valid(valid3),
    .evt_ready(ready3), .pending_cnt(pend3), .overflow(ovf3),
    .clear_ovf(clr3)
  );

  typedef struct {
    int    cyc;
    string nm;
    int    ch;
    int    cnt;
    bit    vld;
    bit    ovf;
    bit    d3;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   acc [NUM_CH] = '{default: 0};
  int   exp_acc [NUM_CH] = '{2, 5, 2, 0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_at(input int at, input string nm, input int ch,
                           input int cnt, input bit vld, input bit ovf,
                           input bit d3 = 1'b0);
    exp_t e;
    e.cyc = at; e.nm = nm; e.ch = ch; e.cnt = cnt; e.vld = vld; e.ovf = ovf; e.d3 = d3;
    sb.push_back(e);
  endtask

  task automatic compare(input exp_t e);
    int gc;
    bit gv, go;
    if (e.d3) begin
      gc = int'(pend3); gv = valid3[0]; go = ovf3[0];
    end else begin
      gc = int'(pending_cnt[e.ch*CNT_W +: CNT_W]); gv = evt_valid[e.ch]; go = overflow[e.ch];
    end
    checks++;
    if (gc != e.cnt || gv != e.vld || go != e.ovf) begin
      errors++;
      $display("FAIL %s cyc%0d ch%0d%s: got cnt=%0d vld=%0d ovf=%0d, want cnt=%0d vld=%0d ovf=%0d",
               e.nm, e.cyc, e.ch, e.d3 ? "(S3)" : "", gc, gv, go, e.cnt, e.vld, e.ovf);
    end
  endtask

  always @(negedge clk) begin
    exp_t nq[$];
    nq = {};
    foreach (sb[i]) begin
      if (sb[i].cyc == cyc) begin
        compare(sb[i]);
      end else if (sb[i].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for cyc %0d not sampled (now %0d)", sb[i].nm, sb[i].cyc, cyc);
      end else begin
        nq.push_back(sb[i]);
      end
    end
    sb = nq;
    if (!rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (evt_valid[c] && evt_ready[c]) acc[c]++;
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic flip(input int ch);
    tog[ch] = ~tog[ch];
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tog = '0; evt_ready = '0; clear_ovf = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      expect_at(2,  "reset",  c, 0, 0, 0);
      expect_at(12, "idle10", c, 0, 0, 0);
      expect_at(22, "idle20", c, 0, 0, 0);
    end
    expect_at(2, "reset", 0, 0, 0, 0, 1'b1);
    tick(2);
    rst = 1'b0;
    tick(20);

    // Latency: level change sampled at edge 23 appears after 25 (S=2), 26 (S=3)
    flip(0);
    expect_at(24, "lat2_early", 0, 0, 0, 0);
    expect_at(25, "lat2",       0, 1, 1, 0);
    expect_at(25, "lat3_early", 0, 0, 0, 0, 1'b1);
    expect_at(26, "lat3",       0, 1, 1, 0, 1'b1);
    tick(5);
    evt_ready[0] = 1'b1;
    tick();
    evt_ready[0] = 1'b0;
    expect_at(28, "ch0_drain", 0, 0, 0, 0);

    // Burst of five events on ch1 while stalled
    for (int k = 1; k <= 5; k++) begin
      flip(1);
      expect_at(cyc + 3, "burst_q", 1, k, 1, 0);
      tick(3);
    end
    evt_ready[1] = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      expect_at(43 + j, "burst_drain", 1, 5 - j, (5 - j) != 0, 0);
    end
    expect_at(48, "untouched", 0, 0, 0, 0);
    expect_at(48, "untouched", 2, 0, 0, 0);
    expect_at(48, "untouched", 3, 0, 0, 0);
    tick(6);
    evt_ready[1] = 1'b0;
    expect_at(49, "no_underflow", 1, 0, 0, 0);

    // Build cnt=3 on ch2, then inc and dec in the same cycle
    for (int k = 1; k <= 3; k++) begin
      flip(2);
      expect_at(cyc + 3, "ch2_fill", 2, k, 1, 0);
      tick(3);
    end
    flip(2);
    tick(2);
    evt_ready[2] = 1'b1;
    tick();
    evt_ready[2] = 1'b0;
    expect_at(61, "incdec3", 2, 3, 1, 0);
    expect_at(62, "incdec3_hold", 2, 3, 1, 0);

    // Fill ch2 to 15, then inc and dec at max
    for (int k = 4; k <= 15; k++) begin
      flip(2);
      expect_at(cyc + 3, "ch2_fill", 2, k, 1, 0);
      tick(3);
    end
    flip(2);
    tick(2);
    evt_ready[2] = 1'b1;
    tick();
    evt_ready[2] = 1'b0;
    expect_at(100, "incdec_max", 2, 15, 1, 0);
    expect_at(101, "incdec_max_hold", 2, 15, 1, 0);

    // Saturation: 17 events on ch3
    for (int k = 1; k <= 17; k++) begin
      flip(3);
      expect_at(cyc + 3, "sat", 3, (k > 15) ? 15 : k, 1, k > 15);
      tick(3);
    end
    clear_ovf[3] = 1'b1;
    tick();
    clear_ovf[3] = 1'b0;
    expect_at(152, "clear_ovf", 3, 15, 1, 0);
    flip(3);
    tick(2);
    expect_at(154, "pre_set_clear", 3, 15, 1, 0);
    clear_ovf[3] = 1'b1;
    tick();
    clear_ovf[3] = 1'b0;
    expect_at(155, "set_beats_clear", 3, 15, 1, 1);

    // Reset mid-burst with toggle_in[0] left high
    for (int k = 1; k <= 4; k++) begin
      flip(0);
      expect_at(cyc + 3, "ch0_fill", 0, k, 1, 0);
      tick(3);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      expect_at(168, "mid_reset", c, 0, 0, 0);
    end
    expect_at(168, "mid_reset", 0, 0, 0, 0, 1'b1);
    expect_at(170, "post_rst_early", 0, 0, 0, 0);
    expect_at(171, "post_rst_evt",   0, 1, 1, 0);
    expect_at(174, "post_rst_once",  0, 1, 1, 0);
    expect_at(180, "post_rst_once",  0, 1, 1, 0);
    expect_at(171, "post_rst_early", 0, 0, 0, 0, 1'b1);
    expect_at(172, "post_rst_evt",   0, 1, 1, 0, 1'b1);
    tick(12);
    evt_ready[0] = 1'b1;
    tick();
    evt_ready[0] = 1'b0;
    expect_at(181, "post_rst_drain", 0, 0, 0, 0);
    tick(3);

    for (int c = 0; c < NUM_CH; c++) begin
      checks++;
      if (acc[c] != exp_acc[c]) begin
        errors++;
        $display("FAIL accepts ch%0d: got %0d, want %0d", c, acc[c], exp_acc[c]);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
